// File: rtl/arbiter_rr_lock.sv
// Round-robin arbiter with packet lock: a grant is held until the winner's last beat, then priority rotates.
// Optional per-grant beat quota when ARBITER_RR_LOCK_QUOTA_EN is defined (MAX_BURST beats max per grant).
module arbiter_rr_lock #(
  parameter int NUM_REQ   = 4,
  parameter int SEL_W     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic               ap_clk,
  input  logic               areset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic               ack,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               valid
);

  if (NUM_REQ < 1 || MAX_BURST < 1 ||
      SEL_W != ((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)) begin : g_param_err
    $error("arbiter_rr_lock: illegal NUM_REQ/SEL_W/MAX_BURST combination");
  end

  typedef enum logic {IDLE, LOCK} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d, sel_q, sel_d;
  logic [SEL_W-1:0]   rot_ptr, base, win_idx;
  logic [NUM_REQ-1:0] grant_q, grant_d, win_oh;
  logic               valid_q, valid_d;
  logic               win_found, beat, quota_hit, rel, new_grant;

  assign beat = valid_q & ack;

  // Next pointer wraps at NUM_REQ, not at 2^SEL_W.
  always_comb begin
    rot_ptr = '0;
    if (int'(sel_q) < NUM_REQ - 1) rot_ptr = sel_q + 1'b1;
  end

  // Release on the granted requester's last beat (or quota), or abort when it drops req without a beat.
  assign rel  = (state_q == LOCK) &&
                ((beat && (req_last[sel_q] || quota_hit)) || (!beat && !req[sel_q]));
  assign base = (state_q == LOCK) ? rot_ptr : ptr_q;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(base) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found   = 1'b1;
        win_idx     = SEL_W'(idx);
        win_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          state_d = LOCK;
          grant_d = win_oh;
          sel_d   = win_idx;
          valid_d = 1'b1;
        end
      end
      LOCK: begin
        if (rel) begin
          ptr_d = rot_ptr;
          if (enable && win_found) begin
            grant_d = win_oh;
            sel_d   = win_idx;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign new_grant = (state_d == LOCK) && ((state_q == IDLE) || rel);

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

`ifdef ARBITER_RR_LOCK_QUOTA_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts beats already taken, so the MAX_BURST-th beat forces release.
  assign quota_hit = (cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant)  cnt_d = '0;
    else if (beat)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_ng;
  assign unused_ng = new_grant;
  assign quota_hit = 1'b0;
`endif

  assign grant  = grant_q;
  assign select = sel_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_arbiter_rr_lock.sv
// Scoreboard bench for arbiter_rr_lock: 4- and 3-requester instances, plus a MAX_BURST=4 instance in quota builds.
module tb_arbiter_rr_lock;

  typedef struct packed {
    logic       v;
    logic [3:0] g;
    logic [1:0] s;
  } exp_t;

  logic       ap_clk = 1'b0;
  logic       areset;
  logic       en4, ack4, en3, ack3;
  logic [3:0] req4, last4, grant4, grantq;
  logic [2:0] req3, last3, grant3;
  logic [1:0] sel4, sel3, selq;
  logic       valid4, valid3, validq;

  exp_t q[$];
  exp_t e;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 ap_clk = ~ap_clk;

  arbiter_rr_lock #(.NUM_REQ(4), .SEL_W(2), .MAX_BURST(16)) u4 (
    .ap_clk(ap_clk), .areset(areset), .enable(en4), .req(req4), .req_last(last4),
    .ack(ack4), .grant(grant4), .select(sel4), .valid(valid4));

  arbiter_rr_lock #(.NUM_REQ(3), .SEL_W(2), .MAX_BURST(16)) u3 (
    .ap_clk(ap_clk), .areset(areset), .enable(en3), .req(req3), .req_last(last3),
    .ack(ack3), .grant(grant3), .select(sel3), .valid(valid3));

  arbiter_rr_lock #(.NUM_REQ(4), .SEL_W(2), .MAX_BURST(4)) uq (
    .ap_clk(ap_clk), .areset(areset), .enable(en4), .req(req4), .req_last(last4),
    .ack(ack4), .grant(grantq), .select(selq), .valid(validq));

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    req4 = '0; last4 = '0; ack4 = 1'b0; en4 = 1'b1;
    req3 = '0; last3 = '0; ack3 = 1'b0; en3 = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if ({valid4, grant4, sel4} !== 7'b0) $display("FAIL reset4: got v=%b g=%b s=%0d want 0/0000/0", valid4, grant4, sel4);
    else pass_cnt++;
    chk_cnt++;
    if ({valid3, grant3, sel3} !== 6'b0) $display("FAIL reset3: got v=%b g=%b s=%0d want 0/000/0", valid3, grant3, sel3);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req4 = 4'b1111; last4 = 4'b1111; ack4 = 1'b1;
    chk_cnt++;
    if (valid4 !== 1'b0) $display("FAIL b2b_pre: valid=%b want 0", valid4);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      q.push_back('{v: 1'b1, g: seq[i], s: (i == 4) ? 2'd0 : 2'(i)});
      tick();
      e = q.pop_front();
      chk_cnt++;
      if ({valid4, grant4, sel4} !== {e.v, e.g, e.s})
        $display("FAIL b2b[%0d]: got v=%b g=%b s=%0d want v=%b g=%b s=%0d", i, valid4, grant4, sel4, e.v, e.g, e.s);
      else pass_cnt++;
    end
    req4 = '0;
    q.push_back('{v: 1'b0, g: 4'b0000, s: 2'd0});
    tick();
    e = q.pop_front();
    chk_cnt++;
    if ({valid4, grant4, sel4} !== {e.v, e.g, e.s})
      $display("FAIL b2b_idle: got v=%b g=%b s=%0d want v=%b g=%b s=%0d", valid4, grant4, sel4, e.v, e.g, e.s);
    else pass_cnt++;
  endtask

  task automatic test_nonpow2();
    do_reset();
    req3 = 3'b101; last3 = 3'b111; ack3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q.push_back('{v: 1'b1, g: (i % 2 == 0) ? 4'b0001 : 4'b0100, s: (i % 2 == 0) ? 2'd0 : 2'd2});
      tick();
      e = q.pop_front();
      chk_cnt++;
      if ({valid3, 1'b0, grant3, sel3} !== {e.v, e.g, e.s})
        $display("FAIL n3[%0d]: got v=%b g=%b s=%0d want v=%b g=%b s=%0d", i, valid3, grant3, sel3, e.v, e.g[2:0], e.s);
      else pass_cnt++;
    end
    req3 = '0;
  endtask

  task automatic test_lock();
    do_reset();
    req4 = 4'b0011;
    q.push_back('{v: 1'b1, g: 4'b0001, s: 2'd0});
    tick();
    e = q.pop_front();
    chk_cnt++;
    if ({valid4, grant4, sel4} !== {e.v, e.g, e.s})
      $display("FAIL lock_grant: got v=%b g=%b s=%0d want v=%b g=%b s=%0d", valid4, grant4, sel4, e.v, e.g, e.s);
    else pass_cnt++;
    // Beats land on even i; last on non-beat cycles and others' last bits must be ignored.
    for (int i = 0; i < 9; i++) begin
      ack4  = (i % 2 == 0);
      last4 = (i == 8) ? 4'b0001 : (ack4 ? 4'b1110 : 4'b1111);
      q.push_back((i == 8) ? '{v: 1'b1, g: 4'b0010, s: 2'd1} : '{v: 1'b1, g: 4'b0001, s: 2'd0});
      tick();
      e = q.pop_front();
      chk_cnt++;
      if ({valid4, grant4, sel4} !== {e.v, e.g, e.s})
        $display("FAIL lock[%0d]: got v=%b g=%b s=%0d want v=%b g=%b s=%0d", i, valid4, grant4, sel4, e.v, e.g, e.s);
      else pass_cnt++;
    end
    // Requester 1 aborts with no beat: idle, select keeps 1.
    req4 = '0; ack4 = 1'b0; last4 = '0;
    q.push_back('{v: 1'b0, g: 4'b0000, s: 2'd1});
    tick();
    e = q.pop_front();
    chk_cnt++;
    if ({valid4, grant4, sel4} !== {e.v, e.g, e.s})
      $display("FAIL abort: got v=%b g=%b s=%0d want v=%b g=%b s=%0d", valid4, grant4, sel4, e.v, e.g, e.s);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_lock();
    exp_t ex [5];
    ex = '{'{v: 1'b1, g: 4'b0100, s: 2'd2}, '{v: 1'b1, g: 4'b0100, s: 2'd2},
           '{v: 1'b1, g: 4'b0100, s: 2'd2}, '{v: 1'b0, g: 4'b0000, s: 2'd0},
           '{v: 1'b1, g: 4'b0100, s: 2'd2}};
    do_reset();
    req4 = 4'b0100; last4 = '0; ack4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      areset = (i == 3);
      if (i == 4) req4 = 4'b1100;
      q.push_back(ex[i]);
      tick();
      e = q.pop_front();
      chk_cnt++;
      if ({valid4, grant4, sel4} !== {e.v, e.g, e.s})
        $display("FAIL rstlock[%0d]: got v=%b g=%b s=%0d want v=%b g=%b s=%0d", i, valid4, grant4, sel4, e.v, e.g, e.s);
      else pass_cnt++;
    end
    areset = 1'b0;
  endtask

  task automatic test_enable();
    exp_t ex [5];
    ex = '{'{v: 1'b1, g: 4'b0001, s: 2'd0}, '{v: 1'b1, g: 4'b0001, s: 2'd0},
           '{v: 1'b0, g: 4'b0000, s: 2'd0}, '{v: 1'b0, g: 4'b0000, s: 2'd0},
           '{v: 1'b1, g: 4'b0010, s: 2'd1}};
    do_reset();
    req4 = 4'b0011; last4 = '0; ack4 = 1'b0; en4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        1: en4 = 1'b0;
        2: begin ack4 = 1'b1; last4 = 4'b0001; end
        3: begin ack4 = 1'b0; last4 = '0; req4 = 4'b0010; end
        4: en4 = 1'b1;
        default: ;
      endcase
      q.push_back(ex[i]);
      tick();
      e = q.pop_front();
      chk_cnt++;
      if ({valid4, grant4, sel4} !== {e.v, e.g, e.s})
        $display("FAIL enable[%0d]: got v=%b g=%b s=%0d want v=%b g=%b s=%0d", i, valid4, grant4, sel4, e.v, e.g, e.s);
      else pass_cnt++;
    end
  endtask

  task automatic test_quota();
`ifdef ARBITER_RR_LOCK_QUOTA_EN
    do_reset();
    req4 = 4'b1001; last4 = 4'b1000; ack4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q.push_back((i == 4) ? '{v: 1'b1, g: 4'b1000, s: 2'd3} : '{v: 1'b1, g: 4'b0001, s: 2'd0});
      tick();
      e = q.pop_front();
      chk_cnt++;
      if ({validq, grantq, selq} !== {e.v, e.g, e.s})
        $display("FAIL quota[%0d]: got v=%b g=%b s=%0d want v=%b g=%b s=%0d", i, validq, grantq, selq, e.v, e.g, e.s);
      else pass_cnt++;
    end
    req4 = '0;
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_nonpow2();
    test_lock();
    test_reset_mid_lock();
    test_enable();
    test_quota();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
